// File: rtl/instruction_fetch.sv
// Instruction fetch front end: reads two consecutive bytes from a synchronous
// byte ROM, assembles a 16-bit word and hands it to decode over valid/ready.
module instruction_fetch #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDRESS_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]     rom_data,
  output logic [2*DATA_WIDTH-1:0]   instr,
  output logic [ADDRESS_WIDTH-1:0]  instr_pc,
  output logic [ADDRESS_WIDTH-1:0]  instr_next_ip,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  input  logic                      redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]  redirect_addr
);

  typedef enum logic [1:0] {
    REQ_HI,
    REQ_LO,
    WAIT_LO,
    VALID
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] pc_plus1;
  logic [DATA_WIDTH-1:0]    hi_byte;
  logic                     handshake;

  assign pc_plus1      = pc + ADDRESS_WIDTH'(1);
  assign instr_next_ip = instr_pc + ADDRESS_WIDTH'(2);
  assign rom_addr      = (state_q == REQ_HI) ? pc : pc_plus1;
  assign handshake     = instr_valid & instr_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ_HI:  state_d = REQ_LO;
      REQ_LO:  state_d = WAIT_LO;
      WAIT_LO: state_d = VALID;
      VALID:   if (handshake) state_d = REQ_HI;
      default: state_d = REQ_HI;
    endcase
    // A redirect abandons whatever fetch is in flight, from any state.
    if (redirect_valid) state_d = REQ_HI;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ_HI;
      pc          <= '0;
      hi_byte     <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc          <= redirect_addr;
        instr_valid <= 1'b0;
      end else begin
        unique case (state_q)
          REQ_LO: hi_byte <= rom_data;
          WAIT_LO: begin
            instr       <= {hi_byte, rom_data};
            instr_pc    <= pc;
            instr_valid <= 1'b1;
          end
          VALID: begin
            if (handshake) begin
              instr_valid <= 1'b0;
              pc          <= pc + ADDRESS_WIDTH'(2);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch against a small synchronous ROM image.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [15:0] instr;
  logic [3:0]  instr_pc;
  logic [3:0]  instr_next_ip;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [3:0]  redirect_addr;

  logic [7:0]  mem [16];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  instruction_fetch #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_next_ip (instr_next_ip),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_word(input string tag, input logic [15:0] w,
                            input logic [3:0] pc, input logic [3:0] nip);
    check({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, ".instr"}, {16'd0, instr}, {16'd0, w});
    check({tag, ".pc"},    {28'd0, instr_pc}, {28'd0, pc});
    check({tag, ".nip"},   {28'd0, instr_next_ip}, {28'd0, nip});
  endtask

  task automatic redirect(input logic [3:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    step(1);
    redirect_valid = 1'b0;
    check("redir.invalid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h0C; mem[1] = 8'h04; mem[2]  = 8'h40; mem[3]  = 8'h05;
    mem[9] = 8'h40; mem[10] = 8'h07; mem[11] = 8'h08; mem[12] = 8'h02;
    mem[15] = 8'hAA;
    rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_addr = '0;

    // 1: reset state, first two words with ready high
    step(2);
    check("rst.valid", {31'd0, instr_valid}, 32'd0);
    check("rst.instr", {16'd0, instr}, 32'd0);
    check("rst.pc",    {28'd0, instr_pc}, 32'd0);
    check("rst.nip",   {28'd0, instr_next_ip}, 32'd2);
    check("rst.addr",  {28'd0, rom_addr}, 32'd0);
    rst = 1'b0;
    step(2);
    check("t1.c2.valid", {31'd0, instr_valid}, 32'd0);
    step(1);
    check_word("t1.w0", 16'h0C04, 4'd0, 4'd2);
    step(4);
    check_word("t1.w1", 16'h4005, 4'd2, 4'd4);

    // 2: stall for 5 cycles, outputs must hold
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_word("t2.hold", 16'h4005, 4'd2, 4'd4);
      check("t2.addr", {28'd0, rom_addr}, 32'd3);
    end
    instr_ready = 1'b1;
    step(4);
    check_word("t2.next", 16'h0000, 4'd4, 4'd6);

    // 3: redirect coinciding with acceptance of 0x4005
    instr_ready = 1'b0;
    redirect(4'd2);
    instr_ready = 1'b1;
    step(3);
    check_word("t3.pre", 16'h4005, 4'd2, 4'd4);
    redirect(4'd9);
    step(2);
    check("t3.c3.valid", {31'd0, instr_valid}, 32'd0);
    step(1);
    check_word("t3.w9", 16'h4007, 4'd9, 4'd11);
    step(4);
    check_word("t3.w11", 16'h0802, 4'd11, 4'd13);

    // 4: redirect while in REQ_LO of pc=0
    redirect(4'd0);
    step(1);
    check("t4.reqlo.addr", {28'd0, rom_addr}, 32'd1);
    redirect(4'd11);
    step(2);
    check("t4.c3.valid", {31'd0, instr_valid}, 32'd0);
    step(1);
    check_word("t4.w11", 16'h0802, 4'd11, 4'd13);

    // 5: wrap-around from address 15
    redirect(4'd15);
    step(3);
    check_word("t5.w15", 16'hAA0C, 4'd15, 4'd1);
    check("t5.addr", {28'd0, rom_addr}, 32'd0);
    step(4);
    check_word("t5.w1", 16'h0440, 4'd1, 4'd3);

    // 6: reset during WAIT_LO of pc=2
    redirect(4'd2);
    step(2);
    rst = 1'b1;
    step(1);
    check("t6.valid", {31'd0, instr_valid}, 32'd0);
    check("t6.instr", {16'd0, instr}, 32'd0);
    check("t6.addr",  {28'd0, rom_addr}, 32'd0);
    rst = 1'b0;
    step(3);
    check_word("t6.w0", 16'h0C04, 4'd0, 4'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
